// File: rtl/adc_cfg_sched_if.sv
// Request/acknowledge and loader-drive bundle of the ADC configuration scheduler.
// The calibration side is the master; the scheduler is the slave.
interface adc_cfg_sched_if #(
    parameter int unsigned NCH = 3
) ();
    logic [NCH-1:0]   REQ;
    logic [6*NCH-1:0] REQ_GAIN;
    logic [9*NCH-1:0] REQ_OFFSET;
    logic [NCH-1:0]   ACK;
    logic             BUSY;
    logic [1:0]       CUR_CH;
    logic             ADC_ENABLE;
    logic [5:0]       ADC_GAIN;
    logic [8:0]       ADC_OFFSET;

    modport master (
        output REQ, REQ_GAIN, REQ_OFFSET,
        input  ACK, BUSY, CUR_CH, ADC_ENABLE, ADC_GAIN, ADC_OFFSET
    );

    modport slave (
        input  REQ, REQ_GAIN, REQ_OFFSET,
        output ACK, BUSY, CUR_CH, ADC_ENABLE, ADC_GAIN, ADC_OFFSET
    );
endinterface

// File: rtl/adc_cfg_sched.sv
// Round-robin scheduler sharing one ADC configuration serial loader between NCH requesters.
// Each grant produces one loader frame: LOAD (1 cycle), SHIFT (SHIFT_LEN), GAP (GAP_LEN).
module adc_cfg_sched #(
    parameter int unsigned NCH       = 3,
    parameter int unsigned SHIFT_LEN = 52,
    parameter int unsigned GAP_LEN   = 4
) (
    input logic            CLK,
    input logic            RST,
    adc_cfg_sched_if.slave bus
);

    localparam int unsigned CntMax = (SHIFT_LEN > GAP_LEN) ? SHIFT_LEN : GAP_LEN;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    typedef enum logic [1:0] {StIdle, StLoad, StShift, StGap} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic [NCH-1:0]  pend_q, pend_d;
    logic [5:0]      gain_st_q [NCH];
    logic [5:0]      gain_st_d [NCH];
    logic [8:0]      off_st_q  [NCH];
    logic [8:0]      off_st_d  [NCH];

    // Last granted channel; granted_q distinguishes "never granted" so the first search starts at 0
    logic [1:0]      ptr_q;
    logic            granted_q;

    logic            enable_q, busy_q;
    logic [5:0]      gain_q;
    logic [8:0]      offset_q;
    logic [1:0]      cur_ch_q;
    logic [NCH-1:0]  ack_q, ack_d;

    logic            grant_vld;
    logic [1:0]      grant_idx;
    logic            grant;

    // Round-robin search for the first pending channel after the last grant
    always_comb begin
        int unsigned start;
        int unsigned idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        start     = granted_q ? ((int'(ptr_q) + 1) % NCH) : 0;
        for (int unsigned k = 0; k < NCH; k++) begin
            idx = (start + k) % NCH;
            if (!grant_vld && pend_q[idx]) begin
                grant_vld = 1'b1;
                grant_idx = 2'(idx);
            end
        end
    end

    assign grant = (state_q == StIdle) && grant_vld;

    // Frame sequencing and per-channel acknowledge generation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        unique case (state_q)
            StIdle: begin
                if (grant_vld) state_d = StLoad;
            end
            StLoad: begin
                state_d = StShift;
                cnt_d   = '0;
            end
            StShift: begin
                if (cnt_q == CntW'(SHIFT_LEN - 1)) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (cnt_q == CntW'(GAP_LEN - 1)) state_d = StIdle;
                else                             cnt_d   = cnt_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
        // ACK lands on the last GAP cycle, so it is decided from the next-state values
        if (state_d == StGap && cnt_d == CntW'(GAP_LEN - 1)) ack_d[cur_ch_q] = 1'b1;
    end

    // Request capture; a request in its own grant cycle re-arms the flag with fresh values
    always_comb begin
        pend_d   = pend_q;
        gain_st_d = gain_st_q;
        off_st_d  = off_st_q;
        if (grant) pend_d[grant_idx] = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (bus.REQ[i]) begin
                pend_d[i]    = 1'b1;
                gain_st_d[i] = bus.REQ_GAIN[6*i +: 6];
                off_st_d[i]  = bus.REQ_OFFSET[9*i +: 9];
            end
        end
    end

    // State, capture storage and registered outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            pend_q    <= '0;
            ptr_q     <= '0;
            granted_q <= 1'b0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            gain_q    <= '0;
            offset_q  <= '0;
            cur_ch_q  <= '0;
            ack_q     <= '0;
            for (int unsigned i = 0; i < NCH; i++) begin
                gain_st_q[i] <= '0;
                off_st_q[i]  <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            gain_st_q <= gain_st_d;
            off_st_q  <= off_st_d;
            enable_q  <= (state_d == StShift);
            busy_q    <= (state_d != StIdle);
            ack_q     <= ack_d;
            if (grant) begin
                gain_q    <= gain_st_q[grant_idx];
                offset_q  <= off_st_q[grant_idx];
                cur_ch_q  <= grant_idx;
                ptr_q     <= grant_idx;
                granted_q <= 1'b1;
            end
        end
    end

    assign bus.ACK        = ack_q;
    assign bus.BUSY       = busy_q;
    assign bus.CUR_CH     = cur_ch_q;
    assign bus.ADC_ENABLE = enable_q;
    assign bus.ADC_GAIN   = gain_q;
    assign bus.ADC_OFFSET = offset_q;

endmodule

// File: tb/tb_adc_cfg_sched.sv
// Directed bench for adc_cfg_sched with a simple MSB-first serial loader model.
module tb_adc_cfg_sched;

    logic clk = 1'b0;
    logic rst;

    adc_cfg_sched_if #(.NCH(3)) ifc ();

    adc_cfg_sched #(
        .NCH(3),
        .SHIFT_LEN(52),
        .GAP_LEN(4)
    ) dut (
        .CLK(clk),
        .RST(rst),
        .bus(ifc)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    // Loader model: latches GAIN/OFFSET while ENABLE is low, shifts MSB first while high
    logic [51:0] spi_sh = '0;
    logic        sdata;
    always @(posedge clk) begin
        if (!ifc.ADC_ENABLE) spi_sh <= {ifc.ADC_GAIN, ifc.ADC_OFFSET, 37'd0};
        else                 spi_sh <= spi_sh << 1;
    end
    assign sdata = spi_sh[51];

    // Monitor sampled on the falling edge
    int          en_cnt   = 0;
    int          busy_cnt = 0;
    logic        en_prev  = 1'b0;
    logic [51:0] sd_word  = '0;
    int          ack_log [$];
    int          fr_ch   [$];
    int          fr_gain [$];
    int          fr_off  [$];
    logic [51:0] fr_sd   [$];

    always @(negedge clk) begin
        if (ifc.ADC_ENABLE) begin
            en_cnt++;
            sd_word = {sd_word[50:0], sdata};
        end
        if (ifc.ADC_ENABLE && !en_prev) begin
            fr_ch.push_back(int'(ifc.CUR_CH));
            fr_gain.push_back(int'(ifc.ADC_GAIN));
            fr_off.push_back(int'(ifc.ADC_OFFSET));
        end
        if (!ifc.ADC_ENABLE && en_prev) fr_sd.push_back(sd_word);
        for (int i = 0; i < 3; i++) if (ifc.ACK[i]) ack_log.push_back(i);
        if (ifc.BUSY) busy_cnt++;
        en_prev = ifc.ADC_ENABLE;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        en_cnt   = 0;
        busy_cnt = 0;
        ack_log.delete();
        fr_ch.delete();
        fr_gain.delete();
        fr_off.delete();
        fr_sd.delete();
    endtask

    task automatic set_ch(input int ch, input logic [5:0] g, input logic [8:0] o);
        ifc.REQ[ch]               = 1'b1;
        ifc.REQ_GAIN[6*ch +: 6]   = g;
        ifc.REQ_OFFSET[9*ch +: 9] = o;
    endtask

    task automatic wait_acks(input string tag, input int n, input int budget);
        for (int c = 0; c < budget && ack_log.size() < n; c++) tick();
        chk(tag, 64'(ack_log.size()), 64'(n));
        for (int c = 0; c < 10 && ifc.BUSY; c++) tick();
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        ifc.REQ = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        clr();
    endtask

    logic [5:0] g_hold;
    logic [8:0] o_hold;

    initial begin
        rst            = 1'b1;
        ifc.REQ        = '0;
        ifc.REQ_GAIN   = '0;
        ifc.REQ_OFFSET = '0;
        tick();
        tick();
        tick();
        // Reset values
        chk("rst_enable", 64'(ifc.ADC_ENABLE), 64'(0));
        chk("rst_gain",   64'(ifc.ADC_GAIN),   64'(0));
        chk("rst_offset", 64'(ifc.ADC_OFFSET), 64'(0));
        chk("rst_ack",    64'(ifc.ACK),        64'(0));
        chk("rst_busy",   64'(ifc.BUSY),       64'(0));
        chk("rst_cur_ch", 64'(ifc.CUR_CH),     64'(0));
        rst = 1'b0;
        tick();
        clr();

        // Single write on ch0: cycle 0 = REQ cycle
        set_ch(0, 6'h2A, 9'h155);
        tick();
        ifc.REQ = '0;
        chk("single_c1_busy", 64'(ifc.BUSY), 64'(0));
        tick();
        chk("single_load_en",   64'(ifc.ADC_ENABLE), 64'(0));
        chk("single_load_gain", 64'(ifc.ADC_GAIN),   64'(6'h2A));
        chk("single_load_off",  64'(ifc.ADC_OFFSET), 64'(9'h155));
        chk("single_load_busy", 64'(ifc.BUSY),       64'(1));
        chk("single_load_ch",   64'(ifc.CUR_CH),     64'(0));
        tick();
        chk("single_c3_en", 64'(ifc.ADC_ENABLE), 64'(1));
        repeat (51) tick();
        chk("single_c54_en", 64'(ifc.ADC_ENABLE), 64'(1));
        tick();
        chk("single_c55_en", 64'(ifc.ADC_ENABLE), 64'(0));
        repeat (2) tick();
        chk("single_c57_ack", 64'(ifc.ACK), 64'(0));
        tick();
        chk("single_c58_ack", 64'(ifc.ACK), 64'(3'b001));
        tick();
        chk("single_c59_ack",  64'(ifc.ACK),  64'(0));
        chk("single_c59_busy", 64'(ifc.BUSY), 64'(0));
        chk("single_en_cycles", 64'(en_cnt), 64'(52));
        chk("single_ack_count", 64'(ack_log.size()), 64'(1));
        chk("single_sd_frames", 64'(fr_sd.size()), 64'(1));
        if (fr_sd.size() == 1) begin
            chk("single_sd_gain", 64'(fr_sd[0][51:46]), 64'(6'h2A));
            chk("single_sd_off",  64'(fr_sd[0][45:37]), 64'(9'h155));
        end

        // Round-robin from a fresh reset: all three at once
        do_reset();
        set_ch(0, 6'h01, 9'h011);
        set_ch(1, 6'h02, 9'h022);
        set_ch(2, 6'h03, 9'h033);
        tick();
        ifc.REQ = '0;
        wait_acks("rr3_acks", 3, 300);
        if (ack_log.size() == 3 && fr_ch.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rr3_ack%0d", k),  64'(ack_log[k]), 64'(k));
                chk($sformatf("rr3_ch%0d", k),   64'(fr_ch[k]),   64'(k));
                chk($sformatf("rr3_gain%0d", k), 64'(fr_gain[k]), 64'(k + 1));
                chk($sformatf("rr3_off%0d", k),  64'(fr_off[k]),  64'(17 * (k + 1)));
            end
        end
        chk("rr3_busy_end", 64'(ifc.BUSY), 64'(0));

        // After ch2, 101 must give ch0 then ch2
        clr();
        set_ch(0, 6'h10, 9'h100);
        set_ch(2, 6'h12, 9'h102);
        tick();
        ifc.REQ = '0;
        wait_acks("rr2_acks", 2, 250);
        if (ack_log.size() == 2 && fr_ch.size() == 2) begin
            chk("rr2_ack0", 64'(ack_log[0]), 64'(0));
            chk("rr2_ack1", 64'(ack_log[1]), 64'(2));
            chk("rr2_ch0",  64'(fr_ch[0]),   64'(0));
            chk("rr2_ch1",  64'(fr_ch[1]),   64'(2));
        end

        // Overwrite of ch1 while ch0 is shifting
        clr();
        set_ch(0, 6'h20, 9'h0AA);
        tick();
        ifc.REQ = '0;
        set_ch(1, 6'h05, 9'h010);
        tick();
        ifc.REQ = '0;
        repeat (8) tick();
        chk("ovw_shifting", 64'(ifc.ADC_ENABLE), 64'(1));
        set_ch(1, 6'h05, 9'h1FF);
        tick();
        ifc.REQ = '0;
        wait_acks("ovw_acks", 2, 250);
        repeat (100) tick();
        chk("ovw_total_acks", 64'(ack_log.size()), 64'(2));
        if (ack_log.size() == 2 && fr_off.size() == 2) begin
            chk("ovw_ack1",   64'(ack_log[1]), 64'(1));
            chk("ovw_ch1",    64'(fr_ch[1]),   64'(1));
            chk("ovw_off1",   64'(fr_off[1]),  64'(9'h1FF));
            chk("ovw_sd_off", 64'(fr_sd[1][45:37]), 64'(9'h1FF));
        end

        // Collision: new ch2 values in ch2's grant cycle
        clr();
        set_ch(2, 6'h31, 9'h0C3);
        tick();
        set_ch(2, 6'h0E, 9'h1E1);
        tick();
        ifc.REQ = '0;
        chk("col_load_gain", 64'(ifc.ADC_GAIN),   64'(6'h31));
        chk("col_load_off",  64'(ifc.ADC_OFFSET), 64'(9'h0C3));
        wait_acks("col_acks", 2, 250);
        if (ack_log.size() == 2 && fr_gain.size() == 2) begin
            chk("col_ack0",  64'(ack_log[0]), 64'(2));
            chk("col_ack1",  64'(ack_log[1]), 64'(2));
            chk("col_gain0", 64'(fr_gain[0]), 64'(6'h31));
            chk("col_gain1", 64'(fr_gain[1]), 64'(6'h0E));
            chk("col_off1",  64'(fr_off[1]),  64'(9'h1E1));
        end

        // Idle hold
        tick();
        clr();
        g_hold = ifc.ADC_GAIN;
        o_hold = ifc.ADC_OFFSET;
        repeat (1000) tick();
        chk("idle_en_cycles",   64'(en_cnt),         64'(0));
        chk("idle_busy_cycles", 64'(busy_cnt),       64'(0));
        chk("idle_gain",        64'(ifc.ADC_GAIN),   64'(6'h0E));
        chk("idle_off",         64'(ifc.ADC_OFFSET), 64'(9'h1E1));
        chk("idle_gain_hold",   64'(ifc.ADC_GAIN),   64'(g_hold));

        // Reset abort at SHIFT count 20 with ch1 pending
        set_ch(0, 6'h11, 9'h0F0);
        set_ch(1, 6'h22, 9'h00F);
        tick();
        ifc.REQ = '0;
        repeat (22) tick();
        chk("abort_pre_en", 64'(ifc.ADC_ENABLE), 64'(1));
        chk("abort_pre_ch", 64'(ifc.CUR_CH),     64'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_en",   64'(ifc.ADC_ENABLE), 64'(0));
        chk("abort_busy", 64'(ifc.BUSY),       64'(0));
        chk("abort_ack",  64'(ifc.ACK),        64'(0));
        clr();
        repeat (200) tick();
        chk("abort_no_ack",   64'(ack_log.size()), 64'(0));
        chk("abort_no_frame", 64'(en_cnt),         64'(0));
        chk("abort_no_busy",  64'(busy_cnt),       64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
